ysyx_22040632_ifu: RTL

Instruction fetch unit: owns the program counter and issues instruction fetches to the instruction memory port. It buffers returned instructions in a small FIFO and presents them to decode on the if2id fields (pc2id, inst2id). It holds its output while decode stalls, and it redirects on flush or fence.i. It sits between the I-memory/I-cache port and ysyx_22040632_idu.

---
 rtl/ysyx_22040632_riscv_pkg.svh | 15 +
 rtl/ysyx_22040632_ifu_fifo.sv | 65 ++++++
 rtl/ysyx_22040632_ifu.sv | 117 +++++++++++
 3 files changed

// File: rtl/ysyx_22040632_riscv_pkg.svh
// Shared fetch-unit state encoding and reset vector.
`ifndef YSYX_22040632_RISCV_PKG_SVH
`define YSYX_22040632_RISCV_PKG_SVH

`define ysyx_22040632_RESET_PC 32'h8000_0000

package ysyx_22040632_riscv_pkg;
  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2
  } ifu_state_t;
endpackage

`endif

// File: rtl/ysyx_22040632_ifu_fifo.sv
// Flop-based synchronous FIFO holding {pc, inst} pairs for decode.
module ysyx_22040632_ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rrst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [63:0]   push_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [63:0]   head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: nothing reads it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assert property (@(posedge clk) disable iff (!rrst_n) !(push && full && !clear));
endmodule

// File: rtl/ysyx_22040632_ifu.sv
// Instruction fetch unit: PC owner, single-outstanding fetch FSM, and
// instruction buffer feeding decode.
`include "ysyx_22040632_riscv_pkg.svh"

module ysyx_22040632_ifu
  import ysyx_22040632_riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = `ysyx_22040632_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rrst_n,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_inst,
  output logic [31:0] pc2id,
  output logic [31:0] inst2id
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  ifu_state_t    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   hold_pc_q, hold_pc_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          kill_q, kill_d;
  logic          accept, push, pop, full, empty;
  logic [CW-1:0] count, count_after;
  logic [63:0]   head;
  logic [31:0]   redir_pc;
  logic          unused_redir_lsbs;

  assign redir_pc          = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lsbs = ^redirect_pc[1:0];

  // A flush caught while offering keeps the old address on the bus until
  // the memory takes it; the redirect target waits in fetch_pc.
  assign req_valid = rrst_n && (state_q == IFU_REQ);
  assign req_addr  = (state_q == IFU_REQ && kill_q) ? hold_pc_q : fetch_pc_q;
  assign accept    = req_valid && req_ready;
  assign push      = (state_q == IFU_WAIT) && resp_valid && !kill_q && !flush;
  assign pop       = !id_stall && !empty;
  assign pc2id     = empty ? 32'h0 : head[63:32];
  assign inst2id   = empty ? 32'h0 : head[31:0];

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    hold_pc_d     = hold_pc_q;
    inflight_pc_d = inflight_pc_q;
    kill_d        = kill_q;
    count_after   = count + CW'(push) - CW'(pop);
    unique case (state_q)
      IFU_IDLE: begin
        if (flush || !full) state_d = IFU_REQ;
        if (flush) fetch_pc_d = redir_pc;
      end
      IFU_REQ: begin
        if (accept) begin
          inflight_pc_d = req_addr;
          state_d       = IFU_WAIT;
          if (!kill_q) fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (flush) begin
          hold_pc_d = req_addr;
        end
        if (flush) begin
          kill_d     = 1'b1;
          fetch_pc_d = redir_pc;
        end
      end
      IFU_WAIT: begin
        if (resp_valid) begin
          kill_d = 1'b0;
          if (kill_q || flush) state_d = IFU_REQ;
          else state_d = (count_after < CW'(FIFO_DEPTH)) ? IFU_REQ : IFU_IDLE;
        end else if (flush) begin
          kill_d = 1'b1;
        end
        if (flush) fetch_pc_d = redir_pc;
      end
      default: state_d = IFU_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q       <= IFU_REQ;
      fetch_pc_q    <= RESET_PC;
      hold_pc_q     <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      kill_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      hold_pc_q     <= hold_pc_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  ysyx_22040632_ifu_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rrst_n    (rrst_n),
    .push      (push),
    .pop       (pop),
    .clear     (flush),
    .push_data ({inflight_pc_q, resp_inst}),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );
endmodule
